// File: rtl/interrupt_controller.sv
// Four-line priority interrupt controller handing one request at a time to the control unit.
// Define IRQ_EDGE_EN for edge-triggered pending bits; the default build uses level-mode pending.
module interrupt_controller #(
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int unsigned VEC_STRIDE = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:0]  IrqIn,
  input  logic        MaskWr,
  input  logic [3:0]  MaskData,
  input  logic        IntEnable,
  input  logic        IntAck,
  input  logic        IntDone,
  output logic        IntReq,
  output logic [1:0]  IntId,
  output logic [31:0] VectorAddr,
  output logic [3:0]  Pending,
  output logic [3:0]  MaskOut,
  output logic        InService
);

  // state      | meaning
  // ST_IDLE    | nothing requested; waiting for an eligible pending line
  // ST_REQ     | IntReq raised for line id_q, waiting for IntAck
  // ST_SERVICE | ISR for line id_q running, waiting for IntDone
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

  state_t     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] mask_q, mask_d;
  logic [1:0] id_q, id_d;
  logic       int_req_q, int_req_d;
  logic       in_service_q, in_service_d;
  logic [3:0] eligible;
  logic [1:0] first_id;

  assign eligible = pending_q & mask_q & {4{IntEnable}};

  // Scan from the top so the lowest eligible index wins.
  always_comb begin
    first_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eligible[i]) first_id = 2'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          state_d = ST_REQ;
          id_d    = first_id;
        end
      end
      ST_REQ: begin
        if (IntAck) begin
          state_d = ST_SERVICE;
        end else if (!IntEnable || !eligible[id_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (IntDone) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    int_req_d    = (state_d == ST_REQ);
    in_service_d = (state_d == ST_SERVICE);
  end

  always_comb begin
    mask_d = mask_q;
    if (MaskWr) mask_d = MaskData;
  end

`ifdef IRQ_EDGE_EN
  logic [3:0] irq_prev_q, irq_prev_d;
  logic [3:0] ack_clr;

  // A rising edge in the same cycle as the ack clear keeps the bit set.
  always_comb begin
    irq_prev_d = IrqIn;
    ack_clr    = '0;
    if (state_q == ST_REQ && IntAck) ack_clr = 4'b0001 << id_q;
    pending_d  = (pending_q & ~ack_clr) | (IrqIn & ~irq_prev_q);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) irq_prev_q <= '0;
    else        irq_prev_q <= irq_prev_d;
  end
`else
  always_comb begin
    pending_d = IrqIn;
  end
`endif

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      mask_q       <= 4'hF;
      id_q         <= '0;
      int_req_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      id_q         <= id_d;
      int_req_q    <= int_req_d;
      in_service_q <= in_service_d;
    end
  end

  assign IntReq     = int_req_q;
  assign IntId      = id_q;
  assign Pending    = pending_q;
  assign MaskOut    = mask_q;
  assign InService  = in_service_q;
  assign VectorAddr = VEC_BASE + 32'(id_q) * 32'(VEC_STRIDE);

endmodule
